// File: rtl/values_ram_arbiter_pkg.sv
// Shared definitions for the values RAM arbiter: sequencer state encoding,
// port indices and the saturating starvation counter helper.
package values_ram_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_SETUP    = 2'd1,
        ARB_STROBE   = 2'd2,
        ARB_COMPLETE = 2'd3
    } arb_state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam logic [3:0] STARVE_MAX = 4'd15;

    function automatic logic [3:0] starve_inc(input logic [3:0] cnt);
        return (cnt == STARVE_MAX) ? cnt : cnt + 4'd1;
    endfunction

endpackage

// File: rtl/values_ram_arbiter_rr_grant.sv
// Two-port winner picker: round-robin on last_grant, or CPU priority with a
// starvation counter that forces the debug port after STARVE_LIMIT CPU wins.
module rr_grant
    import values_ram_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic prio_mode,
    input  logic accept,
    output logic winner
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic       last_grant_q, last_grant_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;

    always_comb begin
        winner = PORT_CPU;
        if (req0 && req1) begin
            if (prio_mode) begin
                winner = (starve_cnt_q >= LIMIT) ? PORT_DBG : PORT_CPU;
            end else begin
                winner = ~last_grant_q;
            end
        end else if (req1) begin
            winner = PORT_DBG;
        end
    end

    // Counter only grows while the debug port is actually left waiting.
    always_comb begin
        last_grant_d = last_grant_q;
        starve_cnt_d = starve_cnt_q;
        if (accept && (req0 || req1)) begin
            last_grant_d = winner;
            if (!prio_mode || (winner == PORT_DBG) || !req1) begin
                starve_cnt_d = 4'd0;
            end else begin
                starve_cnt_d = starve_inc(starve_cnt_q);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= PORT_DBG;
            starve_cnt_q <= 4'd0;
        end else begin
            last_grant_q <= last_grant_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/values_ram_arbiter.sv
// Shares the single-port values RAM between the CPU control unit and the
// debug/loader port; each access runs setup, RAM clock strobe, completion.
module values_ram_arbiter
    import values_ram_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int CPU_PRIORITY = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_clk,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              ram_we_q, ram_we_d;
    logic              ram_clk_q, ram_clk_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dbg_ack_q, dbg_ack_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              busy_q, busy_d;

    logic winner;
    logic grant_accept;

    assign grant_accept = (state_q == ARB_IDLE);

    rr_grant #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_rr_grant (
        .clk      (clk),
        .reset    (reset),
        .req0     (cpu_req),
        .req1     (dbg_req),
        .prio_mode(CPU_PRIORITY != 0),
        .accept   (grant_accept),
        .winner   (winner)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = ram_we_q;
        ram_clk_d   = ram_clk_q;
        cpu_ack_d   = 1'b0;
        dbg_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        busy_d      = busy_q;

        case (state_q)
            ARB_IDLE: begin
                if (cpu_req || dbg_req) begin
                    // The RAM output registers double as the access latches.
                    owner_d   = winner;
                    state_d   = ARB_SETUP;
                    busy_d    = 1'b1;
                    ram_clk_d = 1'b0;
                    if (winner == PORT_DBG) begin
                        ram_addr_d  = dbg_addr;
                        ram_wdata_d = dbg_wdata;
                        ram_we_d    = dbg_we;
                    end else begin
                        ram_addr_d  = cpu_addr;
                        ram_wdata_d = cpu_wdata;
                        ram_we_d    = cpu_we;
                    end
                end
            end
            ARB_SETUP: begin
                state_d   = ARB_STROBE;
                ram_clk_d = 1'b1;
            end
            ARB_STROBE: begin
                // ram_rdata is valid after the strobe's rising edge.
                state_d   = ARB_COMPLETE;
                ram_clk_d = 1'b0;
                ram_we_d  = 1'b0;
                if (owner_q == PORT_DBG) begin
                    dbg_ack_d = 1'b1;
                    if (!ram_we_q) begin
                        dbg_rdata_d = ram_rdata;
                    end
                end else begin
                    cpu_ack_d = 1'b1;
                    if (!ram_we_q) begin
                        cpu_rdata_d = ram_rdata;
                    end
                end
            end
            ARB_COMPLETE: begin
                state_d = ARB_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d   = ARB_IDLE;
                busy_d    = 1'b0;
                ram_clk_d = 1'b0;
                ram_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            owner_q     <= PORT_CPU;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            ram_clk_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            ram_clk_q   <= ram_clk_d;
            cpu_ack_q   <= cpu_ack_d;
            dbg_ack_q   <= dbg_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_we    = ram_we_q;
    assign ram_clk   = ram_clk_q;
    assign cpu_ack   = cpu_ack_q;
    assign dbg_ack   = dbg_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dbg_rdata = dbg_rdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_values_ram_arbiter.sv
// Bench for values_ram_arbiter: a round-robin instance and a CPU-priority
// instance, each with its own RAM model and transaction-level reference.
`timescale 1ns/1ps
module tb_values_ram_arbiter;

    typedef struct {
        bit         port;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         cyc;
    } txn_t;

    typedef struct {
        bit         port;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    logic [1:0]      cpu_req, cpu_we, dbg_req, dbg_we;
    logic [1:0][7:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic [1:0]      cpu_ack, dbg_ack, ram_we, ram_clk, busy;
    logic [1:0][7:0] cpu_rdata, dbg_rdata, ram_addr, ram_wdata;
    logic [7:0]      ram_rdata0, ram_rdata1;
    logic [7:0]      ram_mem0 [256];
    logic [7:0]      ram_mem1 [256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    values_ram_arbiter u_rr (
        .clk(clk), .reset(rst),
        .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]),
        .cpu_ack(cpu_ack[0]), .cpu_rdata(cpu_rdata[0]),
        .dbg_req(dbg_req[0]), .dbg_we(dbg_we[0]), .dbg_addr(dbg_addr[0]), .dbg_wdata(dbg_wdata[0]),
        .dbg_ack(dbg_ack[0]), .dbg_rdata(dbg_rdata[0]),
        .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]), .ram_we(ram_we[0]), .ram_clk(ram_clk[0]),
        .ram_rdata(ram_rdata0), .busy(busy[0])
    );

    values_ram_arbiter #(.CPU_PRIORITY(1), .STARVE_LIMIT(2)) u_pri (
        .clk(clk), .reset(rst),
        .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]),
        .cpu_ack(cpu_ack[1]), .cpu_rdata(cpu_rdata[1]),
        .dbg_req(dbg_req[1]), .dbg_we(dbg_we[1]), .dbg_addr(dbg_addr[1]), .dbg_wdata(dbg_wdata[1]),
        .dbg_ack(dbg_ack[1]), .dbg_rdata(dbg_rdata[1]),
        .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]), .ram_we(ram_we[1]), .ram_clk(ram_clk[1]),
        .ram_rdata(ram_rdata1), .busy(busy[1])
    );

    // Values RAM models: write or read on the rising edge of the strobe.
    always @(posedge ram_clk[0]) begin
        if (ram_we[0]) ram_mem0[ram_addr[0]] <= ram_wdata[0];
        else           ram_rdata0 <= ram_mem0[ram_addr[0]];
    end
    always @(posedge ram_clk[1]) begin
        if (ram_we[1]) ram_mem1[ram_addr[1]] <= ram_wdata[1];
        else           ram_rdata1 <= ram_mem1[ram_addr[1]];
    end

    function automatic void chk(input string name, input int idx, input logic [31:0] act,
                                input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s idx=%0d cyc=%0d got=%0h want=%0h", name, idx, cyc, act, exp);
        end
    endfunction

    // Reference: one expected transaction per grant; an access occupies four cycles.
    for (genvar g = 0; g < 2; g++) begin : mon
        txn_t       q[$];
        logic [7:0] mem [256];
        bit         lg;
        int         sc;
        int         free_from;
        logic [7:0] exp_cr, exp_dr;

        initial for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'h5A;

        always @(negedge clk) begin
            txn_t f, t;
            bit   act, w;
            int   d;
            if (rst) begin
                q.delete();
                lg = 1'b1; sc = 0; free_from = 0; exp_cr = 8'h00; exp_dr = 8'h00;
                chk("rst_busy", g, busy[g], 0);
                chk("rst_ram_clk", g, ram_clk[g], 0);
                chk("rst_ram_we", g, ram_we[g], 0);
                chk("rst_acks", g, {cpu_ack[g], dbg_ack[g]}, 0);
                chk("rst_ram_addr", g, ram_addr[g], 0);
                chk("rst_ram_wdata", g, ram_wdata[g], 0);
                chk("rst_rdata", g, {cpu_rdata[g], dbg_rdata[g]}, 0);
            end else begin
                act = 1'b0; d = -1; f = '{default: 0};
                if (q.size() > 0) begin
                    f = q[0];
                    d = f.cyc - cyc;
                    act = (d >= 0) && (d <= 2);
                end
                chk("busy", g, busy[g], act);
                chk("ram_clk", g, ram_clk[g], act && d == 1);
                chk("ram_we", g, ram_we[g], act && f.we && d >= 1);
                if (act) begin
                    chk("ram_addr", g, ram_addr[g], f.addr);
                    chk("ram_wdata", g, ram_wdata[g], f.wdata);
                end
                chk("cpu_ack", g, cpu_ack[g], act && d == 0 && !f.port);
                chk("dbg_ack", g, dbg_ack[g], act && d == 0 && f.port);
                if (act && d == 0) begin
                    if (!f.we) begin
                        if (f.port) exp_dr = f.rdata;
                        else        exp_cr = f.rdata;
                    end
                    void'(q.pop_front());
                end
                chk("cpu_rdata", g, cpu_rdata[g], exp_cr);
                chk("dbg_rdata", g, dbg_rdata[g], exp_dr);

                if (cyc >= free_from && (cpu_req[g] || dbg_req[g])) begin
                    if (!(cpu_req[g] && dbg_req[g])) w = dbg_req[g];
                    else if (g == 0)                 w = !lg;
                    else                             w = (sc >= 2);
                    if (g == 1) begin
                        if (w || !dbg_req[g]) sc = 0;
                        else if (sc < 15)     sc++;
                    end
                    lg = w;
                    t.port  = w;
                    t.we    = w ? dbg_we[g] : cpu_we[g];
                    t.addr  = w ? dbg_addr[g] : cpu_addr[g];
                    t.wdata = w ? dbg_wdata[g] : cpu_wdata[g];
                    t.rdata = 8'h00;
                    t.cyc   = cyc + 3;
                    if (t.we) mem[t.addr] = t.wdata;
                    else      t.rdata = mem[t.addr];
                    q.push_back(t);
                    free_from = cyc + 4;
                end
            end
        end
    end

    task automatic set_port(input int g, input bit p, input bit req, input bit we,
                            input logic [7:0] addr, input logic [7:0] wdata);
        if (p) begin
            dbg_req[g] = req; dbg_we[g] = we; dbg_addr[g] = addr; dbg_wdata[g] = wdata;
        end else begin
            cpu_req[g] = req; cpu_we[g] = we; cpu_addr[g] = addr; cpu_wdata[g] = wdata;
        end
    endtask

    function automatic logic get_ack(input int g, input bit p);
        return p ? dbg_ack[g] : cpu_ack[g];
    endfunction

    // Single access from an idle arbiter; returns the ack-time rdata and latency.
    task automatic do_access(input int g, input bit p, input bit we, input logic [7:0] addr,
                             input logic [7:0] wdata, output logic [7:0] rd, output int lat);
        set_port(g, p, 1'b1, we, addr, wdata);
        lat = 0;
        rd  = 8'h00;
        while (1) begin
            @(posedge clk); #2;
            lat++;
            if (lat == 1) begin
                chk("setup_addr", g, ram_addr[g], addr);
                chk("setup_we", g, ram_we[g], we);
                chk("setup_clk", g, ram_clk[g], 0);
                if (we) chk("setup_wdata", g, ram_wdata[g], wdata);
            end
            if (lat == 2) chk("strobe_clk", g, ram_clk[g], 1);
            if (get_ack(g, p)) begin
                rd = p ? dbg_rdata[g] : cpu_rdata[g];
                break;
            end
            if (lat >= 12) begin
                chk("ack_timeout", g, 1, 0);
                break;
            end
        end
        set_port(g, p, 1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge clk); #2;
    endtask

    vec_t       tbl [8];
    bit         exp_ord [2][6];
    bit         ord [2][8];
    int         ocyc [2][8];
    int         nack [2];
    bit         pend [2][2];
    logic [7:0] rd;
    int         lat, n, acks;

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int a = 0; a < 256; a++) begin
            ram_mem0[a] = 8'(a) ^ 8'h5A;
            ram_mem1[a] = 8'(a) ^ 8'h5A;
        end
        rst = 1'b1;
        cpu_req = '0; cpu_we = '0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = '0; dbg_we = '0; dbg_addr = '0; dbg_wdata = '0;

        tbl[0] = '{1'b0, 1'b1, 8'h10, 8'hA5, 8'h00};
        tbl[1] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'hA5};
        tbl[2] = '{1'b0, 1'b0, 8'h20, 8'h00, 8'h7A};
        tbl[3] = '{1'b1, 1'b1, 8'hFF, 8'h3C, 8'hA5};
        tbl[4] = '{1'b0, 1'b0, 8'hFF, 8'h00, 8'h3C};
        tbl[5] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h5A};
        tbl[6] = '{1'b0, 1'b1, 8'h10, 8'h00, 8'h3C};
        tbl[7] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'h00};
        exp_ord[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_ord[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #2;

        for (int i = 0; i < 8; i++) begin
            do_access(0, tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, rd, lat);
            chk("tbl_rdata", i, rd, tbl[i].exp_rdata);
            chk("tbl_latency", i, lat, 3);
        end

        // Both ports requesting continuously, from a fresh reset.
        rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        for (int g = 0; g < 2; g++) begin
            set_port(g, 1'b0, 1'b1, 1'b0, 8'h01, 8'h00);
            set_port(g, 1'b1, 1'b1, 1'b0, 8'h02, 8'h00);
            nack[g] = 0;
        end
        for (int c = 1; c <= 26; c++) begin
            @(posedge clk); #2;
            for (int g = 0; g < 2; g++) begin
                if ((cpu_ack[g] || dbg_ack[g]) && nack[g] < 8) begin
                    ord[g][nack[g]]  = dbg_ack[g];
                    ocyc[g][nack[g]] = c;
                    nack[g]++;
                end
            end
        end
        for (int g = 0; g < 2; g++) begin
            chk("arb_count", g, nack[g], 6);
            for (int k = 0; k < 6; k++) begin
                chk("arb_order", g * 10 + k, ord[g][k], exp_ord[g][k]);
                chk("arb_spacing", g * 10 + k, ocyc[g][k], 3 + 4 * k);
            end
            set_port(g, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            set_port(g, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        end
        repeat (8) @(posedge clk);
        #2;

        // Reset lands in the middle of a write strobe.
        set_port(0, 1'b0, 1'b1, 1'b1, 8'h30, 8'h99);
        n = 0;
        while (!ram_clk[0] && n < 10) begin
            @(posedge clk); #2;
            n++;
        end
        chk("rst_pre_clk", 0, ram_clk[0], 1);
        chk("rst_pre_we", 0, ram_we[0], 1);
        rst = 1'b1;
        #1;
        chk("rst_abort_clk", 0, ram_clk[0], 0);
        chk("rst_abort_we", 0, ram_we[0], 0);
        chk("rst_abort_ack", 0, cpu_ack[0], 0);
        chk("rst_abort_busy", 0, busy[0], 0);
        set_port(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge clk); #1;
        chk("rst_no_ack", 0, cpu_ack[0], 0);
        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk); #2;
        do_access(0, 1'b0, 1'b0, 8'h31, 8'h00, rd, lat);
        chk("post_rst_rdata", 0, rd, 8'h6B);
        chk("post_rst_latency", 0, lat, 3);

        // Requester drops req and moves its address while its access is in SETUP.
        set_port(0, 1'b0, 1'b1, 1'b1, 8'h40, 8'h77);
        @(posedge clk); #2;
        chk("drop_setup_addr", 0, ram_addr[0], 8'h40);
        set_port(0, 1'b0, 1'b0, 1'b1, 8'h55, 8'h11);
        @(posedge clk); #2;
        chk("drop_strobe_addr", 0, ram_addr[0], 8'h40);
        chk("drop_strobe_wdata", 0, ram_wdata[0], 8'h77);
        chk("drop_strobe_clk", 0, ram_clk[0], 1);
        @(posedge clk); #2;
        chk("drop_ack", 0, cpu_ack[0], 1);
        acks = 0;
        repeat (6) begin
            @(posedge clk); #2;
            acks += int'(cpu_ack[0]);
        end
        chk("drop_extra_acks", 0, acks, 0);
        do_access(0, 1'b0, 1'b0, 8'h40, 8'h00, rd, lat);
        chk("drop_readback", 0, rd, 8'h77);
        do_access(0, 1'b0, 1'b0, 8'h55, 8'h00, rd, lat);
        chk("drop_untouched", 0, rd, 8'h0F);

        // Random traffic on both instances against the reference model.
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #2;
            for (int g = 0; g < 2; g++) begin
                for (int p = 0; p < 2; p++) begin
                    if (pend[g][p] && get_ack(g, p[0])) begin
                        pend[g][p] = 1'b0;
                        set_port(g, p[0], 1'b0, 1'b0, 8'h00, 8'h00);
                    end
                    if (!pend[g][p] && c < 1440 && $urandom_range(0, 3) == 0) begin
                        set_port(g, p[0], 1'b1, $urandom_range(0, 1) == 1,
                                 8'($urandom_range(0, 15)), 8'($urandom));
                        pend[g][p] = 1'b1;
                    end
                end
            end
        end
        for (int g = 0; g < 2; g++) begin
            chk("rand_drain", g, {pend[g][1], pend[g][0]}, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/values_ram_arbiter.md
Name: values_ram_arbiter

Overview:
- Shares the single-port values RAM between two requesters: port 0 is the CPU control unit and port 1 is the debug/program-loader port.
- Sequences every access as setup, then RAM clock strobe, then completion. This keeps the explicit RAM-clock-pulse discipline the values RAM requires.
- Grants access by round-robin or by CPU priority with an anti-starvation limit.
- Sits between CPUControl's values_addr/values_data/ew_ram_values/values_ram_clk signals and the values RAM.

Parameters:
- ADDR_W, 8, values RAM address width.
- DATA_W, 8, values RAM data width.
- CPU_PRIORITY, 0: 0 selects round-robin; 1 selects fixed priority to port 0.
- STARVE_LIMIT, 4: in CPU_PRIORITY mode, the number of consecutive port-0 grants while port 1 is waiting before port 1 is forced. Legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  port 0 access request.
- cpu_we  in  1  port 0 write enable (1 = write).
- cpu_addr  in  ADDR_W  port 0 address.
- cpu_wdata  in  DATA_W  port 0 write data.
- cpu_ack  out  1  port 0 completion pulse, 1 cycle.
- cpu_rdata  out  DATA_W  port 0 read data, valid while cpu_ack=1.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata  same as the port 0 signals, for port 1.
- ram_addr  out  ADDR_W  values RAM address.
- ram_wdata  out  DATA_W  values RAM write data.
- ram_we  out  1  values RAM write enable.
- ram_clk  out  1  values RAM clock pulse.
- ram_rdata  in  DATA_W  values RAM read data, valid after the ram_clk rising edge.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - All outputs are 0: ram_addr, ram_wdata, ram_we, ram_clk, both acks, both rdata, busy.
  - last_grant=1, so port 0 wins the first tie.
  - starve_cnt=0.
  - Reset asserted mid-transaction aborts it. No ack is issued, and ram_we/ram_clk drop in the same cycle.
- States: IDLE -> SETUP -> STROBE -> COMPLETE -> IDLE.
- IDLE:
  - Samples the requests at a rising edge.
  - If either req=1: chooses the winner, latches its we/addr/wdata into internal registers and records owner. Next state is SETUP.
  - If no req: stays in IDLE.
- Arbitration, round-robin: with both requesting, the port opposite last_grant wins; otherwise the sole requester wins. last_grant is updated to the winner.
- Arbitration, CPU_PRIORITY=1:
  - Port 0 wins ties while starve_cnt < STARVE_LIMIT.
  - starve_cnt increments on each port-0 grant made while dbg_req=1. It saturates at 15.
  - When starve_cnt=STARVE_LIMIT and dbg_req=1, port 1 wins and starve_cnt clears.
  - Any port-1 grant clears starve_cnt. A port-0 grant with dbg_req=0 also clears it.
- SETUP:
  - Drives ram_addr and ram_wdata from the latched values.
  - Drives ram_we with the latched we.
  - ram_clk=0. busy=1.
- STROBE: ram_clk=1, with address, data and we held stable.
- COMPLETE:
  - ram_clk=0 and ram_we=0.
  - For a read, the owner's rdata register captures ram_rdata. For a write, the owner's rdata is unchanged.
  - The owner's ack=1 for exactly this cycle. Next state is IDLE.
- Latency: a request sampled in IDLE at edge k gets its ack high during cycle k+3.
  - Back-to-back accesses take 4 cycles each.
  - The next IDLE sample happens at the edge that ends COMPLETE.
- Requester rules:
  - Hold req until ack. Deasserting req after the grant does not cancel the access; it completes and acks anyway.
  - req still high at the IDLE edge after ack counts as a new request.
  - Fields are latched at grant, so changing them after the grant does not affect the access in flight.
- Outputs:
  - All outputs are registered; there are no combinational req-to-ram paths.
  - rdata holds its last read value between accesses.
  - The non-owner's ack stays 0.
- Address width rule: addresses pass through unmodified. There is no wrap or range check; the RAM decodes the full ADDR_W.

Decomposition:
- Shared package/include (alongside Definitions.v): the state encodings ARB_IDLE, ARB_SETUP, ARB_STROBE and ARB_COMPLETE (2-bit), plus the port indices PORT_CPU=0 and PORT_DBG=1.
- Sub-module rr_grant: a combinational plus last_grant/starve_cnt registered picker. Inputs are the two requests, the mode and a grant-accept strobe; output is the winner index.
- The sequencing FSM and datapath latches stay in the top module.

Test Plan:
- Port 0 write: cpu_req=1, we=1, addr=0x10, wdata=0xA5.
  - SETUP: ram_addr=0x10, ram_wdata=0xA5, ram_we=1.
  - ram_clk high exactly one cycle.
  - cpu_ack pulses at cycle k+3; dbg_ack stays 0.
- Port 1 read of 0x10 after that write, with ram_rdata=0xA5 modelled: dbg_rdata=0xA5 with dbg_ack=1 at k+3. cpu_rdata is unchanged.
- Round-robin with both ports requesting continuously:
  - Grants alternate cpu, dbg, cpu, dbg, with acks every 4 cycles.
  - The first grant goes to cpu after reset.
- CPU_PRIORITY=1, STARVE_LIMIT=2, both requesting continuously: grant order is cpu, cpu, dbg, cpu, cpu, dbg.
- Reset asserted during STROBE of a write: ram_clk and ram_we go 0 immediately with no ack. After release, a new request completes normally with 3-cycle latency.
- Requester deasserts req in SETUP and changes addr to 0x55: the access completes to the originally latched address, and ack pulses once.
